div_tick_scheduler: RTL and testbench
=====================================

// Module: div_tick_scheduler
// PURPOSE
//  Shares one 4-bit power-of-two clock-divider counter among N_REQ requesters.
//  Round-robin arbiter grants one requester at a time and runs the divider at
//  its selected ratio (/2,/4,/8,/16). Emits exactly burst_len tick pulses, then
//  releases. Sits between peripheral controllers and the common divider counter.
// PARAMETERS
//  N_REQ    4  number of requesters (2..8)
//  CNT_W    4  divider counter width; div_sel range 0..CNT_W-1
//  BURST_W  8  width of per-requester tick count
// PORTS
//  clk        in   1              system clock; all logic on posedge
//  rst        in   1              synchronous, active-low reset
//  req        in   N_REQ          per-requester level request
//  div_sel    in   N_REQ*2        per-requester ratio; slice i = [2i+1:2i], tick period 2^(sel+1)
//  burst_len  in   N_REQ*BURST_W  per-requester tick count, sampled at grant
//  grant      out  N_REQ          one-hot or zero; high for the whole RUN state
//  busy       out  1              state != IDLE
//  tick       out  1              1-cycle divided pulse for the granted requester
//  done       out  N_REQ          1-cycle completion pulse to the granted requester
//  cnt        out  CNT_W          live divider count (debug / shared consumers)
// BEHAVIOUR
//  Reset (rst==0 at posedge): state=IDLE; grant=0, done=0, cnt=0, tick=0, busy=0;
//   RR pointer = 0, so requester 0 has highest priority first. Overrides all events.
//  IDLE: if any req, pick the first set req at or after ptr (wrapping); latch
//   div_sel and burst_len; cnt<=0; tick_count<=0; enter RUN, or DONE if the latched
//   len==0 (done pulse, zero ticks).
//  RUN: cnt<=cnt+1 each cycle, wrapping 4'hF->0. mask = (2<<sel)-1.
//   tick = RUN && ((cnt & mask)==mask), combinational from registers.
//   tick_count increments on each tick. The tick at which tick_count==len-1
//   sends the FSM to DONE on the next edge.
//  DONE: grant=0, done[granted]=1 for one cycle; ptr<=granted+1 (mod N_REQ); ->IDLE.
//  Latency: req sampled in IDLE -> grant high the next cycle (grant cycle 1).
//   Ticks fall in grant cycles 2^(sel+1), 2*2^(sel+1), and so on. DONE is the cycle
//   after the last tick. Minimum gap between grants = 1 IDLE cycle.
//  div_sel/burst_len changes after grant are ignored until the next grant.
//  Simultaneous requests: resolved only by the RR order above; no starvation.
//  Never more than one grant bit high; done is never high in the same cycle as grant.
// CONFIGURATION
//  DIV_TICK_ABORT_EN defined: deasserting req[granted] during RUN sends the FSM to
//   DONE on the next edge (done pulsed, remaining ticks dropped, no tick that cycle).
//  Not defined: req is ignored once granted; the burst always runs to burst_len.
// STRUCTURE
//  Package div_tick_pkg: state typedef {IDLE,RUN,DONE}, DIV_SEL_W=2, default
//   widths, function tick_mask(sel) returning (2<<sel)-1.
//  Sub-module rr_arbiter (req, ptr -> one-hot gnt, idx), combinational.
//   The FSM, divider counter and tick counter live in the top.
// TESTING
//  1. rst=0 for 3 cycles while req=4'hF -> grant=0, done=0, cnt=0, busy=0 throughout.
//  2. req[0], sel=0, len=3 -> ticks in grant cycles 2,4,6; done[0] in cycle 7.
//  3. req=4'b1111 held, all sel=3, len=1 -> grants in order 0,1,2,3,0; each gets
//     one tick at grant cycle 16.
//  4. req[2], len=0 -> grant never rises; done[2] one cycle after the request is sampled; no tick.
//  5. req[1], sel=1, len=4, req dropped after first tick -> ABORT_EN: done[1] the next
//     cycle after 1 tick; without it: 4 ticks, then done[1].
//  6. rst pulsed low mid-RUN (req[3], sel=2, len=5, after 2 ticks) -> next cycle IDLE,
//     grant=0, cnt=0, no done. Re-grant starts at requester 0 priority.

Source files
------------

// File: rtl/div_tick_pkg.sv
// Shared types, default widths and the tick-mask helper for div_tick_scheduler.
package div_tick_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DIV_SEL_W   = 2;
  localparam int MASK_W      = 2 ** DIV_SEL_W;
  localparam int N_REQ_DEF   = 4;
  localparam int CNT_W_DEF   = 4;
  localparam int BURST_W_DEF = 8;

  // Low bits of the divider count that must all be set for a tick: (2<<sel)-1.
  function automatic logic [MASK_W-1:0] tick_mask(input logic [DIV_SEL_W-1:0] sel);
    int m;
    m = (2 << sel) - 1;
    return MASK_W'(m);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set req at or after ptr, wrapping.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] idx
);

  always_comb begin
    int  j;
    logic found;
    // NOTE: every output of a combinational block gets a default first, so no path leaves it holding a value (no latch).
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int i = 0; i < N_REQ; i++) begin
      j = (int'(ptr) + i) % N_REQ;
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/div_tick_scheduler.sv
// Round-robin shared power-of-two divider issuing burst_len ticks per grant.
// Optional DIV_TICK_ABORT_EN: dropping req of the granted requester ends its burst early.
module div_tick_scheduler
  import div_tick_pkg::*;
#(
  parameter int N_REQ   = N_REQ_DEF,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int BURST_W = BURST_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*DIV_SEL_W-1:0] div_sel,
  input  logic [N_REQ*BURST_W-1:0]   burst_len,
  output logic [N_REQ-1:0]           grant,
  output logic                       busy,
  output logic                       tick,
  output logic [N_REQ-1:0]           done,
  output logic [CNT_W-1:0]           cnt
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_t               state;
  logic [IDX_W-1:0]     ptr;
  logic [IDX_W-1:0]     idx_q;
  logic [DIV_SEL_W-1:0] sel_q;
  logic [BURST_W-1:0]   len_q;
  logic [BURST_W-1:0]   tick_count;

  logic [N_REQ-1:0]     arb_gnt;
  logic [IDX_W-1:0]     arb_idx;
  logic [DIV_SEL_W-1:0] new_sel;
  logic [BURST_W-1:0]   new_len;
  logic [CNT_W-1:0]     mask;
  logic [IDX_W-1:0]     ptr_next;
  logic                 last_tick;
  logic                 abort;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req (req),
    .ptr (ptr),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

  assign new_sel   = div_sel[arb_idx*DIV_SEL_W +: DIV_SEL_W];
  assign new_len   = burst_len[arb_idx*BURST_W +: BURST_W];
  assign mask      = CNT_W'(tick_mask(sel_q));
  assign tick      = (state == RUN) && ((cnt & mask) == mask);
  assign last_tick = tick && (tick_count == len_q - BURST_W'(1));
  assign busy      = (state != IDLE);
  assign ptr_next  = (idx_q == IDX_W'(N_REQ - 1)) ? '0 : idx_q + IDX_W'(1);

`ifdef DIV_TICK_ABORT_EN
  assign abort = !req[idx_q];
`else
  assign abort = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      ptr        <= '0;
      idx_q      <= '0;
      sel_q      <= '0;
      len_q      <= '0;
      tick_count <= '0;
      cnt        <= '0;
      grant      <= '0;
      done       <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= '0;
          if (|req) begin
            idx_q      <= arb_idx;
            sel_q      <= new_sel;
            len_q      <= new_len;
            cnt        <= '0;
            tick_count <= '0;
            if (new_len == '0) begin
              // Zero-length burst: completion pulse without ever granting.
              state <= DONE;
              done  <= arb_gnt;
            end else begin
              state <= RUN;
              grant <= arb_gnt;
            end
          end
        end
        RUN: begin
          cnt <= cnt + CNT_W'(1);
          if (tick) tick_count <= tick_count + BURST_W'(1);
          if (last_tick || abort) begin
            state <= DONE;
            grant <= '0;
            done  <= grant;
          end
        end
        DONE: begin
          done  <= '0;
          ptr   <= ptr_next;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          grant <= '0;
          done  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_tick_scheduler.sv
// Self-checking bench for div_tick_scheduler: vector table plus hand-written corner sequences.
module tb_div_tick_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  req = 4'hF;
  logic [7:0]  div_sel = '0;
  logic [31:0] burst_len = '0;
  logic [3:0]  grant;
  logic        busy;
  logic        tick;
  logic [3:0]  done;
  logic [3:0]  cnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  div_tick_scheduler #(.N_REQ(4), .CNT_W(4), .BURST_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .div_sel   (div_sel),
    .burst_len (burst_len),
    .grant     (grant),
    .busy      (busy),
    .tick      (tick),
    .done      (done),
    .cnt       (cnt)
  );

  typedef struct {
    logic [3:0] r;
    logic [1:0] sel;
    logic [7:0] len;
    logic [3:0] gnt;
    int         ticks;
    int         first;
    int         last;
    int         done_c;
    int         period;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Grant cycle c = c-th cycle after the edge that samples req in IDLE.
  task automatic run_burst(input logic [3:0] r, input logic [1:0] sel, input logic [7:0] len,
                           input int drop_at, input int period,
                           output int n_t, output int first_t, output int last_t,
                           output int done_c, output int per_bad, output logic [3:0] gnt_seen,
                           output logic [3:0] done_seen, output int gnt_cycles, output int bad);
    n_t = 0; first_t = 0; last_t = 0; done_c = 0; per_bad = 0;
    gnt_seen = '0; done_seen = '0; gnt_cycles = 0; bad = 0;
    req = r;
    div_sel = {4{sel}};
    burst_len = {4{len}};
    for (int c = 1; c <= 1000; c++) begin
      @(posedge clk); #1;
      if (grant != '0) begin
        gnt_cycles++;
        if (gnt_seen == '0) gnt_seen = grant;
      end
      if (((grant & (grant - 4'd1)) != '0) || (grant != '0 && done != '0)) bad++;
      if (tick) begin
        if (n_t > 0 && (c - last_t) != period) per_bad++;
        n_t++;
        if (first_t == 0) first_t = c;
        last_t = c;
        if (n_t == drop_at) req = '0;
      end
      if (done != '0) begin
        done_c = c;
        done_seen = done;
        req = '0;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    vec_t       vecs [7];
    logic [3:0] rr_exp [5];
    int n_t, first_t, last_t, done_c, per_bad, gnt_cycles, bad;
    logic [3:0] gnt_seen, done_seen;

    vecs[0] = '{4'b0001, 2'd0, 8'd3,   4'b0001, 3,   2,  6,   7,   2};
    vecs[1] = '{4'b0100, 2'd1, 8'd2,   4'b0100, 2,   4,  8,   9,   4};
    vecs[2] = '{4'b1000, 2'd2, 8'd1,   4'b1000, 1,   8,  8,   9,   8};
    vecs[3] = '{4'b0100, 2'd0, 8'd0,   4'b0000, 0,   0,  0,   1,   2};
    vecs[4] = '{4'b0001, 2'd1, 8'd5,   4'b0001, 5,   4,  20,  21,  4};
    vecs[5] = '{4'b0001, 2'd0, 8'd255, 4'b0001, 255, 2,  510, 511, 2};
    vecs[6] = '{4'b0010, 2'd3, 8'd2,   4'b0010, 2,   16, 32,  33,  16};
    rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    // Reset held with all requests asserted.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("rst_grant", grant, 4'b0);
      check("rst_done", done, 4'b0);
      check("rst_cnt", cnt, 4'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_tick", tick, 1'b0);
    end
    rst = 1'b1;

    // Round robin from pointer 0: five bursts, one tick each at grant cycle 16.
    begin
      int g, gc, last_done;
      logic [3:0] prev_grant;
      g = 0; gc = 0; last_done = 0; prev_grant = '0;
      req = 4'hF;
      div_sel = {4{2'd3}};
      burst_len = {4{8'd1}};
      for (int c = 1; c <= 300 && g < 5; c++) begin
        @(posedge clk); #1;
        if (grant != '0 && prev_grant == '0) begin
          gc = 1;
          check("rr_grant", grant, rr_exp[g]);
          if (g > 0) check("rr_gap", c - last_done, 2);
        end else if (grant != '0) begin
          gc++;
        end
        if (tick) check("rr_tick_cycle", gc, 16);
        if (done != '0) begin
          check("rr_done", done, rr_exp[g]);
          check("rr_done_len", gc, 16);
          last_done = c;
          g++;
          if (g == 5) req = '0;
        end
        prev_grant = grant;
      end
      check("rr_bursts", g, 5);
      @(posedge clk); #1;
      check("rr_idle_busy", busy, 1'b0);
    end

    // Table-driven single-requester bursts.
    for (int v = 0; v < 7; v++) begin
      run_burst(vecs[v].r, vecs[v].sel, vecs[v].len, 0, vecs[v].period, n_t, first_t, last_t,
                done_c, per_bad, gnt_seen, done_seen, gnt_cycles, bad);
      check($sformatf("v%0d_grant", v), gnt_seen, vecs[v].gnt);
      check($sformatf("v%0d_ticks", v), n_t, vecs[v].ticks);
      check($sformatf("v%0d_first_tick", v), first_t, vecs[v].first);
      check($sformatf("v%0d_last_tick", v), last_t, vecs[v].last);
      check($sformatf("v%0d_done_cycle", v), done_c, vecs[v].done_c);
      check($sformatf("v%0d_done_bits", v), done_seen, vecs[v].r);
      check($sformatf("v%0d_grant_cycles", v), gnt_cycles,
            (vecs[v].len == 0) ? 0 : vecs[v].done_c - 1);
      check($sformatf("v%0d_period", v), per_bad, 0);
      check($sformatf("v%0d_invariant", v), bad, 0);
      check($sformatf("v%0d_idle", v), {busy, grant, done}, 9'b0);
    end

    // Reset mid-run, then re-grant must restart at requester 0 (pointer was 2).
    begin
      int nt;
      nt = 0;
      req = 4'b1000;
      div_sel = {4{2'd2}};
      burst_len = {4{8'd5}};
      for (int c = 1; c <= 100 && nt < 2; c++) begin
        @(posedge clk); #1;
        if (tick) nt++;
      end
      check("mid_ticks_before_rst", nt, 2);
      check("mid_grant_before_rst", grant, 4'b1000);
      rst = 1'b0;
      @(posedge clk); #1;
      check("mid_rst_grant", grant, 4'b0);
      check("mid_rst_cnt", cnt, 4'b0);
      check("mid_rst_done", done, 4'b0);
      check("mid_rst_busy", busy, 1'b0);
      check("mid_rst_tick", tick, 1'b0);
      rst = 1'b1;
      req = 4'b1001;
      div_sel = {4{2'd0}};
      burst_len = {4{8'd1}};
      @(posedge clk); #1;
      check("mid_regrant", grant, 4'b0001);
      req = '0;
      done_seen = '0;
      for (int c = 0; c < 20 && done_seen == '0; c++) begin
        @(posedge clk); #1;
        done_seen = done;
      end
      check("mid_regrant_done", done_seen, 4'b0001);
      @(posedge clk); #1;
    end

    // Request dropped right after the first tick.
    run_burst(4'b0010, 2'd1, 8'd4, 1, 4, n_t, first_t, last_t, done_c, per_bad, gnt_seen,
              done_seen, gnt_cycles, bad);
    check("drop_grant", gnt_seen, 4'b0010);
    check("drop_first_tick", first_t, 4);
    check("drop_done_bits", done_seen, 4'b0010);
`ifdef DIV_TICK_ABORT_EN
    check("drop_ticks", n_t, 1);
    check("drop_done_cycle", done_c, 5);
`else
    check("drop_ticks", n_t, 4);
    check("drop_last_tick", last_t, 16);
    check("drop_done_cycle", done_c, 17);
`endif
    check("drop_invariant", bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
